// File: rtl/adder_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and
// round-robin pointer helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  // Next round-robin start position after index idx, wrapping at n.
  function automatic logic [MAX_IDX_W-1:0] rr_wrap_inc(
    input logic [MAX_IDX_W-1:0] idx,
    input int unsigned          n
  );
    if (32'(idx) + 32'd1 >= n) return '0;
    return MAX_IDX_W'(32'(idx) + 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ; returns one-hot grant and its index.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  int unsigned slot;
  logic        found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    slot        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // ptr_i < NUM_REQ, so a single subtraction performs the wrap
      slot = 32'(ptr_i) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!found && req_i[slot]) begin
        found         = 1'b1;
        grant_o[slot] = 1'b1;
        grant_idx_o   = ID_W'(slot);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one external combinational adder between
// NUM_REQ requesters, returning tagged sums on a single response channel.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_s,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;
  logic [WIDTH-1:0]   add_a_q;
  logic [WIDTH-1:0]   add_b_q;
  logic [WIDTH-1:0]   sum_q;
  logic [ID_W-1:0]    id_q;
  logic               rsp_valid_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign ptr_d = ID_W'(rr_wrap_inc(MAX_IDX_W'(grant_idx), NUM_REQ));

  // Grant offer is combinational so the handshake completes in the cycle
  // the request appears; suppressed during reset and outside IDLE.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      sum_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            add_a_q <= req_a[grant_idx*WIDTH +: WIDTH];
            add_b_q <= req_b[grant_idx*WIDTH +: WIDTH];
            id_q    <= grant_idx;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          sum_q       <= add_s;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule
